// File: rtl/dffnsre_pipe_bank.sv
// WIDTH x DEPTH register pipeline with per-stage valid bits, global enable, synchronous
// set/flush, registered occupancy count and a parameter-selected capture edge.
module dffnsre_pipe_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter bit          NEG_EDGE = 1'b1
) (
  input  logic                       C,
  input  logic                       R,
  input  logic                       E,
  input  logic                       S,
  input  logic                       FL,
  input  logic [WIDTH-1:0]           D,
  input  logic                       DV,
  output logic [WIDTH-1:0]           Q,
  output logic                       QV,
  output logic [$clog2(DEPTH+1)-1:0] CNT,
  output logic                       FULL,
  output logic                       EMPTY
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [CntW-1:0]             cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    if (E) begin
      data_d = {data_q[DEPTH-2:0], D};
      vld_d  = {vld_q[DEPTH-2:0], DV};
      // Modular arithmetic stays exact because cnt always tracks popcount(vld).
      cnt_d  = cnt_q + CntW'(DV) - CntW'(vld_q[DEPTH-1]);
    end
    if (S) begin
      data_d = '1;
    end
    if (FL) begin
      vld_d = '0;
      cnt_d = '0;
    end
  end

  if (NEG_EDGE) begin : g_neg
    always_ff @(negedge C or posedge R) begin
      if (R) begin
        data_q <= '0;
        vld_q  <= '0;
        cnt_q  <= '0;
      end else begin
        data_q <= data_d;
        vld_q  <= vld_d;
        cnt_q  <= cnt_d;
      end
    end
  end else begin : g_pos
    always_ff @(posedge C or posedge R) begin
      if (R) begin
        data_q <= '0;
        vld_q  <= '0;
        cnt_q  <= '0;
      end else begin
        data_q <= data_d;
        vld_q  <= vld_d;
        cnt_q  <= cnt_d;
      end
    end
  end

  always_comb begin
    Q     = data_q[DEPTH-1];
    QV    = vld_q[DEPTH-1];
    CNT   = cnt_q;
    FULL  = (cnt_q == CntW'(DEPTH));
    EMPTY = (cnt_q == '0);
  end

endmodule

// File: tb/tb_dffnsre_pipe_bank.sv
// Scoreboard bench for dffnsre_pipe_bank (falling-edge build): a queue-of-entries model
// produces expected outputs per active edge; a monitor pops and compares after each edge.
module tb_dffnsre_pipe_bank;

  localparam int unsigned W    = 8;
  localparam int unsigned DP   = 4;
  localparam int unsigned CW   = $clog2(DP + 1);

  logic          C = 1'b0;
  logic          R = 1'b1;
  logic          E = 1'b0, S = 1'b0, FL = 1'b0, DV = 1'b0;
  logic [W-1:0]  D = '0;
  logic [W-1:0]  Q;
  logic          QV, FULL, EMPTY;
  logic [CW-1:0] CNT;

  dffnsre_pipe_bank #(.WIDTH(W), .DEPTH(DP), .NEG_EDGE(1'b1)) dut (
    .C(C), .R(R), .E(E), .S(S), .FL(FL), .D(D), .DV(DV),
    .Q(Q), .QV(QV), .CNT(CNT), .FULL(FULL), .EMPTY(EMPTY)
  );

  always #5 C = ~C;

  typedef struct {
    bit           v;
    logic [W-1:0] d;
  } entry_t;

  typedef struct {
    logic [W-1:0]  q;
    logic          qv;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
  } exp_t;

  entry_t pipe[$];
  exp_t   exp_q[$];
  int     errors = 0;
  int     checks = 0;
  bit           cur_e, cur_s, cur_fl, cur_dv;
  logic [W-1:0] cur_d;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    entry_t z;
    z.v = 1'b0;
    z.d = '0;
    pipe.delete();
    for (int i = 0; i < int'(DP); i++) pipe.push_back(z);
  endfunction

  // Apply one active edge of the specified rules to the model and queue the expected outputs.
  function automatic void model_edge();
    entry_t n;
    exp_t   x;
    int     c = 0;
    if (cur_e) begin
      n.v = cur_dv;
      n.d = cur_d;
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
    if (cur_s)  foreach (pipe[i]) pipe[i].d = '1;
    if (cur_fl) foreach (pipe[i]) pipe[i].v = 1'b0;
    foreach (pipe[i]) if (pipe[i].v) c++;
    x.q     = pipe[DP-1].d;
    x.qv    = pipe[DP-1].v;
    x.cnt   = CW'(c);
    x.full  = (c == int'(DP));
    x.empty = (c == 0);
    exp_q.push_back(x);
  endfunction

  task automatic drive(input bit e, input bit s, input bit fl, input bit dv, input logic [W-1:0] d);
    E = e; S = s; FL = fl; DV = dv; D = d;
    cur_e = e; cur_s = s; cur_fl = fl; cur_dv = dv; cur_d = d;
  endtask

  task automatic edge_apply();
    @(negedge C);
    model_edge();
  endtask

  task automatic step(input bit e, input bit s, input bit fl, input bit dv, input logic [W-1:0] d);
    @(posedge C);
    drive(e, s, fl, dv, d);
    edge_apply();
  endtask

  // Async reset asserted mid-cycle; outputs must clear without any clock edge.
  task automatic do_reset();
    @(posedge C);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    #2 R = 1'b1;
    #1;
    chk("rst_q", 64'(Q), 64'(0));
    chk("rst_qv", 64'(QV), 64'(0));
    chk("rst_cnt", 64'(CNT), 64'(0));
    chk("rst_full", 64'(FULL), 64'(0));
    chk("rst_empty", 64'(EMPTY), 64'(1));
    model_clear();
    exp_q.delete();
    #1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h5A);
    R = 1'b0;
    edge_apply();
  endtask

  // Monitor: one expected record per modelled edge, compared 1 time unit after the edge.
  always @(negedge C) begin
    #1;
    if (!R && exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk("q", 64'(Q), 64'(x.q));
      chk("qv", 64'(QV), 64'(x.qv));
      chk("cnt", 64'(CNT), 64'(x.cnt));
      chk("full", 64'(FULL), 64'(x.full));
      chk("empty", 64'(EMPTY), 64'(x.empty));
    end
    if (!R) chk("cnt_popcount", 64'(dut.cnt_q), 64'($countones(dut.vld_q)));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    #12;
    do_reset();
    // Latency and fill
    step(1, 0, 0, 1, 8'hA5);
    step(1, 0, 0, 1, 8'h3C);
    step(1, 0, 0, 1, 8'h0F);
    step(1, 0, 0, 1, 8'hF0);
    // Full wrap, then drain to empty
    step(1, 0, 0, 1, 8'h11);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'(i));
    // Stall with toggling inputs
    step(1, 0, 0, 1, 8'h77);
    step(1, 0, 0, 1, 8'h88);
    for (int i = 0; i < 3; i++) step(0, 0, 0, i[0], 8'($urandom));
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'h00);
    // Set then set+flush
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 8'(8'h21 + i));
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 1, 1, 8'h00);
    // S pulse between active edges must not take effect
    step(1, 0, 0, 1, 8'h42);
    @(posedge C);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    #2 S = 1'b0;
    cur_s = 1'b0;
    edge_apply();
    // Randomized traffic with a mid-run reset
    for (int i = 0; i < 150; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
           1'($urandom), 8'($urandom));
      if (i == 75) do_reset();
    end
    @(posedge C);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge C);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
